// File: rtl/anc_pkg.sv
// anc_pkg: shared definitions for the ANC sample source.
//   CH_E / CH_X / CH_A / CH_RSV : ADC channel tags
//   SAMPLE_W                    : sample width
//   anc_frame_t                 : one controller frame {e, x, a, u}
package anc_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] CH_E   = 2'd0;
  localparam logic [1:0] CH_X   = 2'd1;
  localparam logic [1:0] CH_A   = 2'd2;
  localparam logic [1:0] CH_RSV = 2'd3;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] e;
    logic signed [SAMPLE_W-1:0] x;
    logic signed [SAMPLE_W-1:0] a;
    logic signed [SAMPLE_W-1:0] u;
  } anc_frame_t;

endpackage

// File: rtl/anc_sample_source_if.sv
// anc_sample_source_if: sample handshake between the sample source and the
// ANC controller.
//   master (source)    : drives in_valid, e_out, x_out, a_out, u_out;
//                        receives controller_ready
//   slave (controller) : mirror image
interface anc_sample_source_if;
  import anc_pkg::*;

  logic                       in_valid;
  logic                       controller_ready;
  logic signed [SAMPLE_W-1:0] e_out;
  logic signed [SAMPLE_W-1:0] x_out;
  logic signed [SAMPLE_W-1:0] a_out;
  logic signed [SAMPLE_W-1:0] u_out;

  modport master (
    output in_valid, e_out, x_out, a_out, u_out,
    input  controller_ready
  );

  modport slave (
    input  in_valid, e_out, x_out, a_out, u_out,
    output controller_ready
  );

endinterface

// File: rtl/anc_frame_fifo.sv
// anc_frame_fifo: first-word-fall-through FIFO of anc_frame_t.
//   clk, rst_n  : clock, async active-low reset (storage cleared to 0)
//   push/data   : write request; accepted when not full, or when full and a
//                 pop happens in the same cycle
//   pop         : advance head (ignored when empty)
//   head        : frame at the read pointer, registered storage
//   full/empty  : status; pointers are AW+1 bits, full = MSBs differ, LSBs equal
//   level       : occupancy 0..DEPTH
module anc_frame_fifo
  import anc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  anc_frame_t  push_data,
  input  logic        pop,
  output anc_frame_t  head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  anc_frame_t  mem_q [DEPTH];
  anc_frame_t  mem_d [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_data;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head  = mem_q[rptr_q[AW-1:0]];
  assign level = wptr_q - rptr_q;

endmodule

// File: rtl/anc_sample_source.sv
// anc_sample_source: assembles channel-tagged ADC words into {e, x, a, u}
// frames and feeds them to the ANC controller through a small FWFT FIFO.
//   clk, rst_n         : clock, async active-low reset
//   adc_valid/chan/data: incoming ADC word (chan 0=e, 1=x, 2=a, 3=reserved)
//   u_cfg              : LMS step size, captured when a frame completes
//   smp (master)       : in_valid / controller_ready handshake + frame fields
//   frame_err          : one-cycle pulse after a reserved or duplicate word
//   drop_cnt           : saturating count of frames dropped on a full FIFO
//   fifo_level         : FIFO occupancy
// Build option ANC_SRC_DROP_CNT_EN: when undefined, drop_cnt is tied to 0
// and no counter is built; frames are still dropped on full.
//
// state   | meaning
// IDLE    | no channel collected (mask == 0)
// COLLECT | partial frame held (mask != 0)
module anc_sample_source
  import anc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adc_valid,
  input  logic [1:0]                 adc_chan,
  input  logic signed [SAMPLE_W-1:0] adc_data,
  input  logic signed [SAMPLE_W-1:0] u_cfg,
  anc_sample_source_if.master        smp,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [AW:0]                fifo_level
);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 mask_q, mask_d;
  logic signed [SAMPLE_W-1:0] hold_e_q, hold_e_d;
  logic signed [SAMPLE_W-1:0] hold_x_q, hold_x_d;
  logic signed [SAMPLE_W-1:0] hold_a_q, hold_a_d;
  logic                       frame_err_q, frame_err_d;

  logic [2:0]  chan_bit;
  logic        push_req;
  anc_frame_t  push_frame;
  anc_frame_t  head;
  logic        fifo_full, fifo_empty;
  logic        in_valid;
  logic        pop;

  assign chan_bit = 3'b001 << adc_chan;

  always_comb begin
    mask_d      = mask_q;
    hold_e_d    = hold_e_q;
    hold_x_d    = hold_x_q;
    hold_a_d    = hold_a_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    push_frame  = '0;

    if (adc_valid) begin
      if (adc_chan == CH_RSV) begin
        frame_err_d = 1'b1;
        mask_d      = 3'b000;
      end else if (state_q == COLLECT && (mask_q & chan_bit) != 3'b000) begin
        // Duplicate channel: the new word starts a fresh frame.
        frame_err_d = 1'b1;
        mask_d      = chan_bit;
      end else if ((mask_q | chan_bit) == 3'b111) begin
        // Completing word bypasses its holding register.
        push_req     = 1'b1;
        mask_d       = 3'b000;
        push_frame.e = (adc_chan == CH_E) ? adc_data : hold_e_q;
        push_frame.x = (adc_chan == CH_X) ? adc_data : hold_x_q;
        push_frame.a = (adc_chan == CH_A) ? adc_data : hold_a_q;
        push_frame.u = u_cfg;
      end else begin
        mask_d = mask_q | chan_bit;
      end

      if (adc_chan == CH_E) hold_e_d = adc_data;
      if (adc_chan == CH_X) hold_x_d = adc_data;
      if (adc_chan == CH_A) hold_a_d = adc_data;
    end

    state_d = (mask_d == 3'b000) ? IDLE : COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      hold_e_q    <= '0;
      hold_x_q    <= '0;
      hold_a_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      hold_e_q    <= hold_e_d;
      hold_x_q    <= hold_x_d;
      hold_a_q    <= hold_a_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_valid = !fifo_empty;
  assign pop      = in_valid && smp.controller_ready;

  anc_frame_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (push_frame),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef ANC_SRC_DROP_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             drop;

  assign drop = push_req && fifo_full && !pop;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign drop_cnt         = '0;
`endif

  assign frame_err    = frame_err_q;
  assign smp.in_valid = in_valid;
  assign smp.e_out    = head.e;
  assign smp.x_out    = head.x;
  assign smp.a_out    = head.a;
  assign smp.u_out    = head.u;

endmodule
